// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter
// Shares one single-port memory between the flash loader, the CPU and the PPU.
// Only one transaction is in flight at a time. A write takes IDLE -> ACCESS -> IDLE.
// A read takes IDLE -> ACCESS -> READ_WAIT -> IDLE. A requester that is acknowledged
// in a cycle sits out arbitration in that same cycle. As a result, two requesters
// that both hold their requests are served alternately.

module nes_mem_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_active,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_d,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_READ_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_LD  = 2'd0,
        OWN_CPU = 2'd1,
        OWN_PPU = 2'd2
    } owner_t;

    state_t              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_d_q,     mem_d_d;
    logic                mem_wren_q,  mem_wren_d;
    logic                ld_ack_q,    ld_ack_d;
    logic                cpu_ack_q,   cpu_ack_d;
    logic                ppu_ack_q,   ppu_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ppu_rdata_q, ppu_rdata_d;
    // 1 means the PPU won the most recent CPU/PPU grant, so the CPU wins the next tie.
    logic                last_ppu_q,  last_ppu_d;

    // A requester that is being acknowledged this cycle cannot win again this cycle.
    logic ld_ok, cpu_ok, ppu_ok;
    assign ld_ok  = ld_req  & ~ld_ack_q;
    assign cpu_ok = cpu_req & ~cpu_ack_q;
    assign ppu_ok = ppu_req & ~ppu_ack_q;

    // Next-state logic: arbitrate in IDLE, then run the memory access for the granted owner.
    always_comb begin
        // NOTE: every _d starts at its hold value, or 0 for pulses, so that no branch infers a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_d_d     = mem_d_q;
        mem_wren_d  = 1'b0;
        ld_ack_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        ppu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ppu_rdata_d = ppu_rdata_q;
        last_ppu_d  = last_ppu_q;

        case (state_q)
            ST_IDLE: begin
                if (load_active) begin
                    // The loader owns memory; CPU and PPU requests stay pending.
                    if (ld_ok) begin
                        state_d    = ST_ACCESS;
                        owner_d    = OWN_LD;
                        mem_addr_d = ld_addr;
                        mem_d_d    = ld_d;
                        mem_wren_d = 1'b1;
                    end
                end else if (cpu_ok && (!ppu_ok || last_ppu_q)) begin
                    state_d    = ST_ACCESS;
                    owner_d    = OWN_CPU;
                    mem_addr_d = cpu_addr;
                    mem_d_d    = cpu_d;
                    mem_wren_d = cpu_we;
                    last_ppu_d = 1'b0;
                end else if (ppu_ok) begin
                    state_d    = ST_ACCESS;
                    owner_d    = OWN_PPU;
                    mem_addr_d = ppu_addr;
                    last_ppu_d = 1'b1;
                end
            end

            ST_ACCESS: begin
                if (mem_wren_q) begin
                    // The write lands in this cycle, so acknowledge it and go back to arbitration.
                    state_d   = ST_IDLE;
                    ld_ack_d  = (owner_q == OWN_LD);
                    cpu_ack_d = (owner_q == OWN_CPU);
                    ppu_ack_d = (owner_q == OWN_PPU);
                end else begin
                    state_d = ST_READ_WAIT;
                end
            end

            ST_READ_WAIT: begin
                // mem_q now holds the data for the address presented in ACCESS.
                state_d = ST_IDLE;
                case (owner_q)
                    OWN_CPU: begin
                        cpu_rdata_d = mem_q;
                        cpu_ack_d   = 1'b1;
                    end
                    OWN_PPU: begin
                        ppu_rdata_d = mem_q;
                        ppu_ack_d   = 1'b1;
                    end
                    default: ;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_LD;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            mem_wren_q  <= 1'b0;
            ld_ack_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ppu_rdata_q <= '0;
            last_ppu_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking updates, so every flop sees the pre-edge values of the others.
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            mem_wren_q  <= mem_wren_d;
            ld_ack_q    <= ld_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            ppu_ack_q   <= ppu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
            last_ppu_q  <= last_ppu_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_d    = mem_d_q;
    assign mem_wren = mem_wren_q;
    assign ld_ack   = ld_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign ppu_ack  = ppu_ack_q;
    assign cpu_q    = cpu_rdata_q;
    assign ppu_q    = ppu_rdata_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// tb_nes_mem_arbiter
// This bench uses a transaction-level reference model. Each grant is recorded
// together with its grant cycle. The model then derives the access cycle, the
// ack cycle and the read data from that record.
// A behavioural memory stands in for the single-port RAM.

module tb_nes_mem_arbiter;

    localparam int AW = 22;
    localparam int DW = 8;

    logic          clock       = 1'b0;
    logic          reset_n     = 1'b0;
    logic          load_active = 1'b0;
    logic          ld_req      = 1'b0;
    logic [AW-1:0] ld_addr     = '0;
    logic [DW-1:0] ld_d        = '0;
    logic          ld_ack;
    logic          cpu_req     = 1'b0;
    logic          cpu_we      = 1'b0;
    logic [AW-1:0] cpu_addr    = '0;
    logic [DW-1:0] cpu_d       = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_q;
    logic          ppu_req     = 1'b0;
    logic [AW-1:0] ppu_addr    = '0;
    logic          ppu_ack;
    logic [DW-1:0] ppu_q;
    logic [AW-1:0] mem_addr;
    logic          mem_wren;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q       = '0;

    int checks = 0;
    int errors = 0;

    nes_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_active (load_active),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_d        (ld_d),
        .ld_ack      (ld_ack),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_d       (cpu_d),
        .cpu_ack     (cpu_ack),
        .cpu_q       (cpu_q),
        .ppu_req     (ppu_req),
        .ppu_addr    (ppu_addr),
        .ppu_ack     (ppu_ack),
        .ppu_q       (ppu_q),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_d       (mem_d),
        .mem_q       (mem_q)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory locations that have never been written read back this fixed pattern.
    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ---------------- behavioural single-port memory (environment) ----------------
    logic [DW-1:0] env_mem [logic [AW-1:0]];

    initial begin : mem_env
        logic [DW-1:0] rd;
        forever begin
            @(posedge clock);
            rd = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
            if (mem_wren) env_mem[mem_addr] = mem_d;
            mem_q <= rd;
        end
    end

    // ---------------- reference model ----------------
    typedef enum int {W_LD, W_CPU, W_PPU} who_e;
    typedef struct {
        who_e          who;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;    // write data, or the expected read data
        int            g;       // index of the cycle in which the request was granted
        int            ack_at;  // index of the cycle in which the ack is high
    } txn_t;

    txn_t          cur;
    bit            cur_valid = 0;
    int            cyc       = 0;   // index of the current cycle; cycle 0 is the first one after reset
    int            idle_from = 0;   // first cycle index in which arbitration happens again
    bit            cpu_last  = 0;   // the CPU won the most recent CPU/PPU grant
    logic [DW-1:0] m_cpu_q   = '0;
    logic [DW-1:0] m_ppu_q   = '0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    initial begin : model
        int   g;
        bit   l_ok, c_ok, p_ok, granted;
        txn_t nt;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                cyc = 0; idle_from = 0; cur_valid = 0; cpu_last = 0;
                m_cpu_q = '0; m_ppu_q = '0;
            end else begin
                cyc++;
                g = cyc - 1;   // this edge closes cycle g
                if (cur_valid && !cur.we && cyc == cur.ack_at) begin
                    if (cur.who == W_CPU) m_cpu_q = cur.data;
                    if (cur.who == W_PPU) m_ppu_q = cur.data;
                end
                if (g >= idle_from) begin
                    l_ok = ld_req  && !(cur_valid && cur.ack_at == g && cur.who == W_LD);
                    c_ok = cpu_req && !(cur_valid && cur.ack_at == g && cur.who == W_CPU);
                    p_ok = ppu_req && !(cur_valid && cur.ack_at == g && cur.who == W_PPU);
                    granted = 0;
                    if (load_active) begin
                        if (l_ok) begin
                            nt.who = W_LD; nt.we = 1; nt.addr = ld_addr; nt.data = ld_d; granted = 1;
                        end
                    end else if (c_ok && (!p_ok || !cpu_last)) begin
                        nt.who = W_CPU; nt.we = cpu_we; nt.addr = cpu_addr; nt.data = cpu_d; granted = 1;
                    end else if (p_ok) begin
                        nt.who = W_PPU; nt.we = 0; nt.addr = ppu_addr; nt.data = '0; granted = 1;
                    end
                    if (granted) begin
                        nt.g = g;
                        nt.ack_at = g + (nt.we ? 2 : 3);
                        if (nt.we) ref_mem[nt.addr] = nt.data;
                        else nt.data = ref_mem.exists(nt.addr) ? ref_mem[nt.addr] : dflt(nt.addr);
                        if (nt.who == W_CPU) cpu_last = 1;
                        if (nt.who == W_PPU) cpu_last = 0;
                        idle_from = nt.ack_at;
                        cur = nt;
                        cur_valid = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin : compare
        bit e_ld, e_cpu, e_ppu, e_wren;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("rst_ld_ack",   ld_ack,   0);
                check("rst_cpu_ack",  cpu_ack,  0);
                check("rst_ppu_ack",  ppu_ack,  0);
                check("rst_mem_wren", mem_wren, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_d",    mem_d,    0);
                check("rst_cpu_q",    cpu_q,    0);
                check("rst_ppu_q",    ppu_q,    0);
            end else begin
                e_ld   = cur_valid && cur.who == W_LD  && cyc == cur.ack_at;
                e_cpu  = cur_valid && cur.who == W_CPU && cyc == cur.ack_at;
                e_ppu  = cur_valid && cur.who == W_PPU && cyc == cur.ack_at;
                e_wren = cur_valid && cur.we && cyc == cur.g + 1;
                check("ld_ack",   ld_ack,   e_ld);
                check("cpu_ack",  cpu_ack,  e_cpu);
                check("ppu_ack",  ppu_ack,  e_ppu);
                check("mem_wren", mem_wren, e_wren);
                if (cur_valid && cyc == cur.g + 1) begin
                    check("mem_addr", mem_addr, cur.addr);
                    if (cur.we) check("mem_d", mem_d, cur.data);
                end
                check("cpu_q", cpu_q, m_cpu_q);
                check("ppu_q", ppu_q, m_ppu_q);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        load_active = 0; ld_req = 0; cpu_req = 0; cpu_we = 0; ppu_req = 0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin : stim
        int prev;
        int n_acks;
        apply_reset();

        // Loader write while the loader owns memory; a simultaneous CPU write waits.
        load_active = 1; ld_req = 1; ld_addr = 22'h00010; ld_d = 8'h4E;
        cpu_req = 1; cpu_we = 1; cpu_addr = 22'h00300; cpu_d = 8'hA5;
        tick();
        check("ld_wren_lit", mem_wren, 1);
        check("ld_addr_lit", mem_addr, 22'h00010);
        check("ld_d_lit",    mem_d,    8'h4E);
        ld_req = 0;
        tick();
        check("ld_ack_lit",  ld_ack,  1);
        check("cpu_blocked", cpu_ack, 0);
        repeat (4) begin
            tick();
            check("cpu_blocked", cpu_ack, 0);
        end

        // load_active falls during ACCESS; the loader write still completes and is acknowledged.
        // The pending CPU write then goes next.
        ld_req = 1; ld_addr = 22'h00020; ld_d = 8'h11;
        tick();
        load_active = 0; ld_req = 0;
        tick();
        check("ld_ack_after_fall", ld_ack, 1);
        tick();
        check("cpu_wr_wren", mem_wren, 1);
        check("cpu_wr_addr", mem_addr, 22'h00300);
        check("cpu_wr_d",    mem_d,    8'hA5);
        cpu_we = 0;
        tick();
        check("cpu_wr_ack", cpu_ack, 1);
        tick();
        check("cpu_masked_idle", mem_wren, 0);
        tick();
        check("cpu_rd_addr", mem_addr, 22'h00300);
        tick();
        tick();
        check("cpu_rd_ack",  cpu_ack, 1);
        check("cpu_rd_q",    cpu_q,   8'hA5);
        check("ppu_q_untouched", ppu_q, 0);
        cpu_req = 0;

        // CPU and PPU contend right after reset: the CPU wins, then the PPU is served.
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 22'h00100;
        ppu_req = 1; ppu_addr = 22'h00200;
        tick();
        check("tie_cpu_first", mem_addr, 22'h00100);
        tick();
        tick();
        check("tie_cpu_ack", cpu_ack, 1);
        check("tie_cpu_q",   cpu_q,   8'h5B);
        check("tie_ppu_wait", ppu_ack, 0);
        cpu_req = 0;
        tick();
        check("tie_ppu_next", mem_addr, 22'h00200);
        ppu_req = 0;
        tick();
        tick();
        check("tie_ppu_ack", ppu_ack, 1);
        check("tie_ppu_q",   ppu_q,   8'h58);
        check("tie_cpu_q_hold", cpu_q, 8'h5B);

        // Assert reset asynchronously during READ_WAIT of a PPU read.
        ppu_req = 1; ppu_addr = 22'h00210;
        tick();
        ppu_req = 0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_ppu_ack",  ppu_ack,  0);
        check("async_mem_addr", mem_addr, 0);
        check("async_mem_d",    mem_d,    0);
        check("async_cpu_q",    cpu_q,    0);
        check("async_ppu_q",    ppu_q,    0);
        tick();
        check("dropped_ppu_ack", ppu_ack, 0);
        reset_n = 1'b1;
        ppu_req = 1; ppu_addr = 22'h00200;
        tick();
        ppu_req = 0;
        tick();
        tick();
        check("post_rst_ppu_ack", ppu_ack, 1);
        check("post_rst_ppu_q",   ppu_q,   8'h58);

        // With both CPU and PPU requesting permanently, grants must strictly alternate.
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 22'h00005;
        ppu_req = 1; ppu_addr = 22'h00006;
        prev = 0;
        n_acks = 0;
        repeat (40) begin
            tick();
            if (cpu_ack || ppu_ack) begin
                n_acks++;
                if (prev != 0) check("rr_alternate", cpu_ack, (prev == 2) ? 1 : 0);
                prev = cpu_ack ? 1 : 2;
            end
        end
        check("rr_ack_count", (n_acks >= 12) ? 1 : 0, 1);

        // Random traffic, checked every cycle by the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) load_active = ~load_active;
            ld_req   = $urandom_range(0, 1) == 1;
            ld_addr  = AW'($urandom_range(0, 15));
            ld_d     = DW'($urandom);
            cpu_req  = $urandom_range(0, 1) == 1;
            cpu_we   = $urandom_range(0, 2) == 0;
            cpu_addr = AW'($urandom_range(0, 15));
            cpu_d    = DW'($urandom);
            ppu_req  = $urandom_range(0, 1) == 1;
            ppu_addr = AW'($urandom_range(0, 15));
            if (i == 1500) apply_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_mem_arbiter.md
NES_MEM_ARBITER -- requirements
Module: nes_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clock  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_active  input  1  high while the flash loader owns memory.
REQ-006 SHALL have port ld_req/ld_addr/ld_d  input  1/ADDR_W/DATA_W  loader write request, address and data.
REQ-007 SHALL have port ld_ack  output  1  one-cycle loader write acknowledge.
REQ-008 SHALL have port cpu_req/cpu_we/cpu_addr/cpu_d  input  1/1/ADDR_W/DATA_W  CPU request, write flag, address and write data.
REQ-009 SHALL have port cpu_ack/cpu_q  output  1/DATA_W  CPU acknowledge and read data.
REQ-010 SHALL have port ppu_req/ppu_addr  input  1/ADDR_W  PPU read request and address.
REQ-011 SHALL have port ppu_ack/ppu_q  output  1/DATA_W  PPU acknowledge and read data.
REQ-012 SHALL have port mem_addr/mem_wren/mem_d  output  ADDR_W/1/DATA_W  single-port memory address, write enable and write data, all registered.
REQ-013 SHALL have port mem_q  input  DATA_W  memory read data, valid one cycle after the address.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> (READ_WAIT, read only) -> IDLE.
REQ-015 In IDLE, any unmasked request SHALL be granted: register its address, data and mem_wren (write = loader, or CPU with cpu_we=1); next state ACCESS.
REQ-016 Requester whose ack is high in the current cycle SHALL be masked from arbitration that cycle.
REQ-017 While load_active=1, only ld_req SHALL be granted; cpu_req/ppu_req are held pending without ack.
REQ-018 While load_active=0, ld_req SHALL be ignored.
REQ-019 CPU vs PPU contention SHALL be resolved round-robin: grant the requester not served last; last_grant reset value = PPU (CPU wins first tie).
REQ-020 Uncontended requests SHALL be granted immediately regardless of last_grant; last_grant updates on every CPU/PPU grant.
REQ-021 ACCESS, write: mem_wren deasserts next cycle, the requester's ack pulses next cycle (write ack visible 2 cycles after the grant cycle), next state IDLE.
REQ-022 ACCESS, read: mem_wren=0, next state READ_WAIT.
REQ-023 READ_WAIT: capture mem_q into cpu_q or ppu_q; pulse that ack next cycle (read ack visible 3 cycles after the grant cycle), next state IDLE.
REQ-024 cpu_q/ppu_q SHALL hold their last value until the next read for that requester; writes SHALL not change them.
REQ-025 Each ack SHALL be high exactly one cycle per transaction; at most one ack high per cycle.
REQ-026 mem_wren SHALL be high only during the ACCESS cycle of a write.
REQ-027 A change of load_active during ACCESS/READ_WAIT SHALL not abort the transaction in flight; it takes effect at the next IDLE arbitration.
REQ-028 Request inputs SHALL be sampled only in IDLE; address/data changes in other states SHALL be ignored.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, all acks 0, mem_wren 0, mem_addr 0, mem_d 0, cpu_q 0, ppu_q 0, last_grant PPU, independent of clock.
REQ-030 Transaction in flight at reset SHALL be dropped without ack; arbitration resumes on the first clock edge after reset_n rises.

Verification
REQ-031 load_active=1, ld_req, ld_addr=0x00010, ld_d=0x4E -> mem_wren=1 with mem_addr=0x00010, mem_d=0x4E one cycle after grant; ld_ack 2 cycles after grant; simultaneous cpu_req never acked.
REQ-032 load_active=0, cpu_req and ppu_req asserted together after reset, cpu_we=0 -> CPU granted first, cpu_ack+cpu_q at grant+3, then PPU granted in the IDLE cycle of cpu_ack, ppu_ack 3 cycles later.
REQ-033 CPU write cpu_addr=0x0300, cpu_d=0xA5, then CPU read 0x0300 (memory model) -> cpu_q=0xA5 on second ack; ppu_q unchanged.
REQ-034 cpu_req and ppu_req held permanently -> grants alternate CPU, PPU, CPU, ...; no requester waits more than one transaction.
REQ-035 reset_n pulsed low during READ_WAIT of a PPU read -> ppu_ack never asserted, all outputs 0 asynchronously, new request after release served normally.
REQ-036 load_active falls during ACCESS of a loader write -> ld_ack still pulses; pending cpu_req granted in the following IDLE.
